// File: rtl/rv_alu_arbiter_if.sv
// Handshake and ALU bus bundle for rv_alu_arbiter: two request/response pairs plus the shared-ALU port.
// The slave modport is the arbiter's view; the master modport is the requesters' and ALU's view.
interface rv_alu_arbiter_if #(
    parameter int XLEN = 64,
    parameter int SELW = 4
);
    logic            req0_valid_i;
    logic            req0_ready_o;
    logic [XLEN-1:0] req0_op1_i;
    logic [XLEN-1:0] req0_op2_i;
    logic [SELW-1:0] req0_sel_i;
    logic            rsp0_valid_o;
    logic            rsp0_ready_i;
    logic [XLEN-1:0] rsp0_result_o;
    logic            rsp0_zero_o;

    logic            req1_valid_i;
    logic            req1_ready_o;
    logic [XLEN-1:0] req1_op1_i;
    logic [XLEN-1:0] req1_op2_i;
    logic [SELW-1:0] req1_sel_i;
    logic            rsp1_valid_o;
    logic            rsp1_ready_i;
    logic [XLEN-1:0] rsp1_result_o;
    logic            rsp1_zero_o;

    logic [XLEN-1:0] alu_op1_o;
    logic [XLEN-1:0] alu_op2_o;
    logic [SELW-1:0] alu_sel_o;
    logic [XLEN-1:0] alu_result_i;
    logic            alu_zero_i;
    logic            busy_o;

    modport slave (
        input  req0_valid_i, req0_op1_i, req0_op2_i, req0_sel_i, rsp0_ready_i,
        input  req1_valid_i, req1_op1_i, req1_op2_i, req1_sel_i, rsp1_ready_i,
        input  alu_result_i, alu_zero_i,
        output req0_ready_o, rsp0_valid_o, rsp0_result_o, rsp0_zero_o,
        output req1_ready_o, rsp1_valid_o, rsp1_result_o, rsp1_zero_o,
        output alu_op1_o, alu_op2_o, alu_sel_o, busy_o
    );

    modport master (
        output req0_valid_i, req0_op1_i, req0_op2_i, req0_sel_i, rsp0_ready_i,
        output req1_valid_i, req1_op1_i, req1_op2_i, req1_sel_i, rsp1_ready_i,
        output alu_result_i, alu_zero_i,
        input  req0_ready_o, rsp0_valid_o, rsp0_result_o, rsp0_zero_o,
        input  req1_ready_o, rsp1_valid_o, rsp1_result_o, rsp1_zero_o,
        input  alu_op1_o, alu_op2_o, alu_sel_o, busy_o
    );
endinterface

// File: rtl/rv_alu_arbiter.sv
// Two-requester arbiter in front of one shared rv_alu (IDLE -> EXEC -> RESP), round-robin on ties.
// Define ALU_ARB_FIXED_PRIO_EN to give requester 0 fixed priority instead.
module rv_alu_arbiter #(
    parameter int XLEN = 64,
    parameter int SELW = 4
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    rv_alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q;
    logic            grant_q;
    logic            any_req;
    logic            win;
    logic            accept;
    logic            rsp_hs;

    logic [XLEN-1:0] alu_op1_p0;
    logic [XLEN-1:0] alu_op2_p0;
    logic [SELW-1:0] alu_sel_p0;

    logic [1:0]      vld_p1;
    logic [XLEN-1:0] res0_p1;
    logic [XLEN-1:0] res1_p1;
    logic            zero0_p1;
    logic            zero1_p1;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic            last_grant_q;
`endif

    // Grant decision: win = 1 selects requester 1.
    always_comb begin
        any_req = bus.req0_valid_i | bus.req1_valid_i;
`ifdef ALU_ARB_FIXED_PRIO_EN
        win = ~bus.req0_valid_i;
`else
        if (bus.req0_valid_i && bus.req1_valid_i) begin
            win = ~last_grant_q;
        end else begin
            win = bus.req1_valid_i;
        end
`endif
    end

    // Readies are gated by rstn_i so nothing looks accepted while reset is held.
    assign accept           = rstn_i && (state_q == IDLE) && any_req;
    assign bus.req0_ready_o = accept & ~win;
    assign bus.req1_ready_o = accept & win;
    assign rsp_hs           = grant_q ? bus.rsp1_ready_i : bus.rsp0_ready_i;

    assign bus.busy_o        = (state_q != IDLE);
    assign bus.alu_op1_o     = alu_op1_p0;
    assign bus.alu_op2_o     = alu_op2_p0;
    assign bus.alu_sel_o     = alu_sel_p0;
    assign bus.rsp0_valid_o  = vld_p1[0];
    assign bus.rsp1_valid_o  = vld_p1[1];
    assign bus.rsp0_result_o = res0_p1;
    assign bus.rsp1_result_o = res1_p1;
    assign bus.rsp0_zero_o   = zero0_p1;
    assign bus.rsp1_zero_o   = zero1_p1;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            alu_op1_p0   <= '0;
            alu_op2_p0   <= '0;
            alu_sel_p0   <= '0;
            vld_p1       <= 2'b00;
            res0_p1      <= '0;
            res1_p1      <= '0;
            zero0_p1     <= 1'b0;
            zero1_p1     <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            case (state_q)
                // Stage p0: winner's operands registered onto the ALU inputs.
                IDLE: begin
                    if (any_req) begin
                        alu_op1_p0 <= win ? bus.req1_op1_i : bus.req0_op1_i;
                        alu_op2_p0 <= win ? bus.req1_op2_i : bus.req0_op2_i;
                        alu_sel_p0 <= win ? bus.req1_sel_i : bus.req0_sel_i;
                        grant_q    <= win;
                        state_q    <= EXEC;
                    end
                end
                // Stage p1: ALU output captured into the winner's response register only.
                EXEC: begin
                    if (grant_q) begin
                        res1_p1  <= bus.alu_result_i;
                        zero1_p1 <= bus.alu_zero_i;
                        vld_p1   <= 2'b10;
                    end else begin
                        res0_p1  <= bus.alu_result_i;
                        zero0_p1 <= bus.alu_zero_i;
                        vld_p1   <= 2'b01;
                    end
`ifndef ALU_ARB_FIXED_PRIO_EN
                    last_grant_q <= grant_q;
`endif
                    state_q <= RESP;
                end
                RESP: begin
                    if (rsp_hs) begin
                        vld_p1  <= 2'b00;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    vld_p1  <= 2'b00;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv_alu_arbiter.sv
// Self-checking bench for rv_alu_arbiter with a behavioural ALU and per-requester response scoreboards.
module tb_rv_alu_arbiter;
    localparam int XLEN = 64;
    localparam int SELW = 4;

    typedef struct packed {
        logic [XLEN-1:0] res;
        logic            zero;
    } exp_t;

    logic clk = 1'b0;
    logic rstn;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    rv_alu_arbiter_if #(.XLEN(XLEN), .SELW(SELW)) bus();

    rv_alu_arbiter #(.XLEN(XLEN), .SELW(SELW)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    function automatic logic [XLEN-1:0] alu_f(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                              input logic [SELW-1:0] s);
        case (s)
            4'b0000: alu_f = a & b;
            4'b0001: alu_f = a | b;
            4'b0010: alu_f = a + b;
            4'b0110: alu_f = a - b;
            default: alu_f = a ^ b;
        endcase
    endfunction

    function automatic exp_t mk_exp(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                    input logic [SELW-1:0] s);
        mk_exp.res  = alu_f(a, b, s);
        mk_exp.zero = (alu_f(a, b, s) == '0);
    endfunction

    assign bus.alu_result_i = alu_f(bus.alu_op1_o, bus.alu_op2_o, bus.alu_sel_o);
    assign bus.alu_zero_i   = (bus.alu_result_i == '0);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0_valid_i = 1'b0; bus.req0_op1_i = '0; bus.req0_op2_i = '0; bus.req0_sel_i = '0;
        bus.req1_valid_i = 1'b0; bus.req1_op1_i = '0; bus.req1_op2_i = '0; bus.req1_sel_i = '0;
        bus.rsp0_ready_i = 1'b1; bus.rsp1_ready_i = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        q0.delete();
        q1.delete();
    endtask

    task automatic test_reset();
        idle_inputs();
        rstn = 1'b0;
        #2;
        bus.req0_valid_i = 1'b1;
        bus.req1_valid_i = 1'b1;
        #1;
        n_cmp++; if (bus.req0_ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_req0_ready got %0b want 0", bus.req0_ready_o); end
        n_cmp++; if (bus.req1_ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_req1_ready got %0b want 0", bus.req1_ready_o); end
        n_cmp++; if (bus.rsp0_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_rsp0_valid got %0b want 0", bus.rsp0_valid_o); end
        n_cmp++; if (bus.rsp1_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_rsp1_valid got %0b want 0", bus.rsp1_valid_o); end
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0b want 0", bus.busy_o); end
        n_cmp++; if (bus.alu_op1_o !== '0) begin n_bad++; $display("FAIL reset_alu_op1 got %0h want 0", bus.alu_op1_o); end
        n_cmp++; if (bus.alu_sel_o !== '0) begin n_bad++; $display("FAIL reset_alu_sel got %0h want 0", bus.alu_sel_o); end
        n_cmp++; if (bus.rsp0_result_o !== '0) begin n_bad++; $display("FAIL reset_rsp0_result got %0h want 0", bus.rsp0_result_o); end
        n_cmp++; if (bus.rsp1_zero_o !== 1'b0) begin n_bad++; $display("FAIL reset_rsp1_zero got %0b want 0", bus.rsp1_zero_o); end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        #1;
        // First tie after reset belongs to requester 0.
        n_cmp++; if (bus.req0_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_first_tie_req0 got %0b want 1", bus.req0_ready_o); end
        n_cmp++; if (bus.req1_ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_first_tie_req1 got %0b want 0", bus.req1_ready_o); end
        idle_inputs();
        step();
    endtask

    task automatic test_single();
        exp_t e;
        do_reset();
        bus.req0_valid_i = 1'b1; bus.req0_op1_i = 64'd5; bus.req0_op2_i = 64'd3; bus.req0_sel_i = 4'b0010;
        #1;
        n_cmp++; if (bus.req0_ready_o !== 1'b1) begin n_bad++; $display("FAIL single_req0_ready got %0b want 1", bus.req0_ready_o); end
        n_cmp++; if (bus.req1_ready_o !== 1'b0) begin n_bad++; $display("FAIL single_req1_ready got %0b want 0", bus.req1_ready_o); end
        if (bus.req0_ready_o === 1'b1) q0.push_back(mk_exp(64'd5, 64'd3, 4'b0010));
        step();
        bus.req0_valid_i = 1'b0;
        #1;
        n_cmp++; if (bus.alu_op1_o !== 64'd5) begin n_bad++; $display("FAIL single_alu_op1 got %0d want 5", bus.alu_op1_o); end
        n_cmp++; if (bus.alu_sel_o !== 4'd2) begin n_bad++; $display("FAIL single_alu_sel got %0d want 2", bus.alu_sel_o); end
        n_cmp++; if (bus.busy_o !== 1'b1) begin n_bad++; $display("FAIL single_busy_exec got %0b want 1", bus.busy_o); end
        n_cmp++; if (bus.rsp0_valid_o !== 1'b0) begin n_bad++; $display("FAIL single_rsp0_early got %0b want 0", bus.rsp0_valid_o); end
        step();
        n_cmp++; if (bus.rsp0_valid_o !== 1'b1) begin n_bad++; $display("FAIL single_rsp0_valid got %0b want 1", bus.rsp0_valid_o); end
        n_cmp++; if (bus.rsp1_valid_o !== 1'b0) begin n_bad++; $display("FAIL single_rsp1_valid got %0b want 0", bus.rsp1_valid_o); end
        n_cmp++;
        if (q0.size() == 0) begin n_bad++; $display("FAIL single_scoreboard got empty want 1 entry"); end
        else begin
            e = q0.pop_front();
            if (bus.rsp0_result_o !== e.res || bus.rsp0_zero_o !== e.zero) begin
                n_bad++; $display("FAIL single_rsp0_data got %0h/%0b want %0h/%0b", bus.rsp0_result_o, bus.rsp0_zero_o, e.res, e.zero);
            end
        end
        step();
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL single_busy_idle got %0b want 0", bus.busy_o); end
        n_cmp++; if (bus.rsp0_result_o !== 64'd8) begin n_bad++; $display("FAIL single_rsp0_hold got %0h want 8", bus.rsp0_result_o); end
    endtask

    // Both requesters valid for 12 cycles: four operations, grant order checked against arbitration policy.
    task automatic test_tie();
        exp_t e;
        int   grants[$];
        int   want;
        do_reset();
        bus.req0_op1_i = 64'd7;    bus.req0_op2_i = 64'd7;    bus.req0_sel_i = 4'b0110;
        bus.req1_op1_i = 64'h0F;   bus.req1_op2_i = 64'hF0;   bus.req1_sel_i = 4'b0001;
        bus.req0_valid_i = 1'b1;   bus.req1_valid_i = 1'b1;
        for (int k = 0; k < 12; k++) begin
            #1;
            n_cmp++; if (bus.req0_ready_o === 1'b1 && bus.req1_ready_o === 1'b1) begin n_bad++; $display("FAIL tie_two_readies cycle %0d got 11 want <=1", k); end
            if (bus.req0_ready_o === 1'b1) begin q0.push_back(mk_exp(bus.req0_op1_i, bus.req0_op2_i, bus.req0_sel_i)); grants.push_back(0); end
            if (bus.req1_ready_o === 1'b1) begin q1.push_back(mk_exp(bus.req1_op1_i, bus.req1_op2_i, bus.req1_sel_i)); grants.push_back(1); end
            if (bus.rsp0_valid_o === 1'b1) begin
                n_cmp++;
                if (q0.size() == 0) begin n_bad++; $display("FAIL tie_rsp0_unexpected got valid want none"); end
                else begin
                    e = q0.pop_front();
                    if (bus.rsp0_result_o !== e.res || bus.rsp0_zero_o !== e.zero) begin
                        n_bad++; $display("FAIL tie_rsp0_data got %0h/%0b want %0h/%0b", bus.rsp0_result_o, bus.rsp0_zero_o, e.res, e.zero);
                    end
                end
            end
            if (bus.rsp1_valid_o === 1'b1) begin
                n_cmp++;
                if (q1.size() == 0) begin n_bad++; $display("FAIL tie_rsp1_unexpected got valid want none"); end
                else begin
                    e = q1.pop_front();
                    if (bus.rsp1_result_o !== e.res || bus.rsp1_zero_o !== e.zero) begin
                        n_bad++; $display("FAIL tie_rsp1_data got %0h/%0b want %0h/%0b", bus.rsp1_result_o, bus.rsp1_zero_o, e.res, e.zero);
                    end
                end
            end
            step();
        end
        n_cmp++; if (grants.size() != 4) begin n_bad++; $display("FAIL tie_grant_count got %0d want 4", grants.size()); end
        for (int i = 0; i < grants.size(); i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            want = 0;
`else
            want = i % 2;
`endif
            n_cmp++; if (grants[i] != want) begin n_bad++; $display("FAIL tie_grant_%0d got %0d want %0d", i, grants[i], want); end
        end
        n_cmp++; if (q0.size() != 0 || q1.size() != 0) begin n_bad++; $display("FAIL tie_leftover got %0d/%0d want 0/0", q0.size(), q1.size()); end
        // Requester 1 must still be served once requester 0 withdraws.
        bus.req0_valid_i = 1'b0;
        #1;
        n_cmp++; if (bus.req1_ready_o !== 1'b1) begin n_bad++; $display("FAIL tie_req1_after_drop got %0b want 1", bus.req1_ready_o); end
        step();
        idle_inputs();
        repeat (3) step();
    endtask

    task automatic test_back_pressure();
        exp_t e;
        int   got;
        do_reset();
        bus.rsp1_ready_i = 1'b0;
        bus.req1_valid_i = 1'b1; bus.req1_op1_i = 64'h10; bus.req1_op2_i = 64'h20; bus.req1_sel_i = 4'b0010;
        #1;
        n_cmp++; if (bus.req1_ready_o !== 1'b1) begin n_bad++; $display("FAIL bp_req1_ready got %0b want 1", bus.req1_ready_o); end
        if (bus.req1_ready_o === 1'b1) q1.push_back(mk_exp(64'h10, 64'h20, 4'b0010));
        step();
        bus.req1_valid_i = 1'b0;
        bus.req0_valid_i = 1'b1; bus.req0_op1_i = 64'd9; bus.req0_op2_i = 64'd4; bus.req0_sel_i = 4'b0110;
        step();
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (bus.rsp1_valid_o !== 1'b1 || bus.rsp1_result_o !== 64'h30 || bus.req0_ready_o !== 1'b0 || bus.busy_o !== 1'b1) begin
                n_bad++; $display("FAIL bp_hold_%0d got v=%0b r=%0h rdy0=%0b busy=%0b want 1/30/0/1", i, bus.rsp1_valid_o, bus.rsp1_result_o, bus.req0_ready_o, bus.busy_o);
            end
            step();
        end
        bus.rsp1_ready_i = 1'b1;
        #1;
        n_cmp++;
        if (q1.size() == 0 || bus.rsp1_valid_o !== 1'b1) begin n_bad++; $display("FAIL bp_release got valid=%0b want 1 with entry", bus.rsp1_valid_o); end
        else begin
            e = q1.pop_front();
            if (bus.rsp1_result_o !== e.res || bus.rsp1_zero_o !== e.zero) begin
                n_bad++; $display("FAIL bp_rsp1_data got %0h/%0b want %0h/%0b", bus.rsp1_result_o, bus.rsp1_zero_o, e.res, e.zero);
            end
        end
        step();
        n_cmp++; if (bus.req0_ready_o !== 1'b1) begin n_bad++; $display("FAIL bp_req0_next got %0b want 1", bus.req0_ready_o); end
        if (bus.req0_ready_o === 1'b1) q0.push_back(mk_exp(64'd9, 64'd4, 4'b0110));
        step();
        bus.req0_valid_i = 1'b0;
        got = 0;
        for (int i = 0; i < 4 && got == 0; i++) begin
            #1;
            if (bus.rsp0_valid_o === 1'b1) begin
                got = 1;
                n_cmp++;
                if (q0.size() == 0) begin n_bad++; $display("FAIL bp_rsp0_unexpected got valid want none"); end
                else begin
                    e = q0.pop_front();
                    if (bus.rsp0_result_o !== e.res || bus.rsp0_zero_o !== e.zero) begin
                        n_bad++; $display("FAIL bp_rsp0_data got %0h/%0b want %0h/%0b", bus.rsp0_result_o, bus.rsp0_zero_o, e.res, e.zero);
                    end
                end
            end
            step();
        end
        if (got == 0) begin n_cmp++; n_bad++; $display("FAIL bp_rsp0_timeout got no valid want valid within 4 cycles"); end
    endtask

    task automatic test_reset_midop();
        exp_t e;
        do_reset();
        bus.req0_valid_i = 1'b1; bus.req0_op1_i = 64'd3; bus.req0_op2_i = 64'd3; bus.req0_sel_i = 4'b0110;
        #1;
        n_cmp++; if (bus.req0_ready_o !== 1'b1) begin n_bad++; $display("FAIL mid_req0_ready got %0b want 1", bus.req0_ready_o); end
        step();
        bus.req1_valid_i = 1'b1;
        #2;
        rstn = 1'b0;
        #1;
        n_cmp++;
        if (bus.req0_ready_o !== 1'b0 || bus.req1_ready_o !== 1'b0 || bus.busy_o !== 1'b0 ||
            bus.rsp0_valid_o !== 1'b0 || bus.rsp1_valid_o !== 1'b0 || bus.alu_op1_o !== '0) begin
            n_bad++; $display("FAIL mid_async_reset got rdy=%0b%0b busy=%0b vld=%0b%0b op1=%0h want all 0",
                              bus.req0_ready_o, bus.req1_ready_o, bus.busy_o, bus.rsp0_valid_o, bus.rsp1_valid_o, bus.alu_op1_o);
        end
        q0.delete();
        q1.delete();
        idle_inputs();
        step();
        rstn = 1'b1;
        bus.req1_valid_i = 1'b1; bus.req1_op1_i = 64'hAA; bus.req1_op2_i = 64'h55; bus.req1_sel_i = 4'b0001;
        #1;
        n_cmp++; if (bus.req1_ready_o !== 1'b1) begin n_bad++; $display("FAIL mid_req1_ready got %0b want 1", bus.req1_ready_o); end
        if (bus.req1_ready_o === 1'b1) q1.push_back(mk_exp(64'hAA, 64'h55, 4'b0001));
        step();
        bus.req1_valid_i = 1'b0;
        #1;
        n_cmp++; if (bus.rsp0_valid_o !== 1'b0) begin n_bad++; $display("FAIL mid_stale_rsp0 got %0b want 0", bus.rsp0_valid_o); end
        step();
        n_cmp++; if (bus.rsp1_valid_o !== 1'b1 || bus.rsp0_valid_o !== 1'b0) begin n_bad++; $display("FAIL mid_rsp_valid got %0b%0b want 10", bus.rsp1_valid_o, bus.rsp0_valid_o); end
        n_cmp++;
        if (q1.size() == 0) begin n_bad++; $display("FAIL mid_scoreboard got empty want 1 entry"); end
        else begin
            e = q1.pop_front();
            if (bus.rsp1_result_o !== e.res || bus.rsp1_zero_o !== e.zero) begin
                n_bad++; $display("FAIL mid_rsp1_data got %0h/%0b want %0h/%0b", bus.rsp1_result_o, bus.rsp1_zero_o, e.res, e.zero);
            end
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rstn = 1'b0;
        test_reset();
        test_single();
        test_tie();
        test_back_pressure();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rv_alu_arbiter.md
Name: rv_alu_arbiter

Overview:
- Shares one `rv_alu` instance between two requesters, e.g. port 0 = execute stage, port 1 = address/branch helper.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- The block arbitrates between requesters, registers the winner's operands onto the shared ALU inputs, and captures the ALU result and zero flag. It returns them to the winner only.
- It sits between the issue logic and the ALU.

Parameters:
- XLEN, 64, operand/result width; matches the ALU datapath.
- SELW, 4, width of the ALU operation select.

Ports:
- clk_i  input  1  single clock; all state updates on rising edge.
- rstn_i  input  1  reset; asynchronous, active-low.
- req0_valid_i  input  1  requester 0 has an operation pending.
- req0_ready_o  output  1  requester 0 operation accepted this cycle.
- req0_op1_i  input  XLEN  requester 0 operand 1.
- req0_op2_i  input  XLEN  requester 0 operand 2.
- req0_sel_i  input  SELW  requester 0 ALU op select.
- rsp0_valid_o  output  1  result for requester 0 available.
- rsp0_ready_i  input  1  requester 0 consumes its result.
- rsp0_result_o  output  XLEN  result for requester 0.
- rsp0_zero_o  output  1  zero flag for requester 0.
- req1_* / rsp1_*: same set of ports and widths, for requester 1.
- alu_op1_o  output  XLEN  registered operand 1 to the ALU.
- alu_op2_o  output  XLEN  registered operand 2 to the ALU.
- alu_sel_o  output  SELW  registered op select to the ALU.
- alu_result_i  input  XLEN  ALU result (combinational from alu_* outputs).
- alu_zero_i  input  1  ALU zero flag.
- busy_o  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values (rstn_i low, asynchronous):
  - FSM = IDLE.
  - All *_valid_o and *_ready_o = 0; busy_o = 0.
  - alu_op1_o, alu_op2_o, alu_sel_o = 0.
  - rsp*_result_o = 0 and rsp*_zero_o = 0.
  - Round-robin pointer last_grant = 1, so requester 0 wins the first tie.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - If any reqN_valid_i is high, compute the grant: a single requester wins outright; with both valid, the winner is the requester that is not last_grant.
  - reqN_ready_o of the winner is high combinationally in this cycle only; this is the acceptance cycle.
  - On the clock edge: latch the winner's op1/op2/sel into alu_*_o, record winner in a grant register, go to EXEC.
  - With no valid request: stay in IDLE; alu_*_o hold their last value.
- EXEC (exactly 1 cycle):
  - Capture alu_result_i and alu_zero_i into the response register.
  - Set last_grant = winner.
  - Go to RESP.
- RESP:
  - rspW_valid_o = 1 for the winner W only; the other rsp valid stays 0.
  - Result/zero are held stable until rspW_ready_i is high at a rising edge, then go to IDLE.
  - rsp*_result_o and rsp*_zero_o hold their value after the handshake.
- reqN_ready_o is 0 in EXEC and RESP; at most one ready is high in any cycle.
- Latency: acceptance in cycle N -> rsp valid in cycle N+2 (with ready already high). Peak throughput is one operation per 3 cycles.
- A requester may lower valid without being granted; no request state is kept for it.
- Operand/select values on non-accepted cycles are ignored.
- Back-pressure: if rspW_ready_i stays low, the FSM stays in RESP indefinitely and the other requester waits.
- Reset mid-operation drops any in-flight operation and any pending response; nothing is replayed.
- No arithmetic in this block; widths pass through unchanged.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined:
  - Requester 0 always wins when both are valid.
  - last_grant is not implemented; requester 1 is granted only when req0_valid_i is low in IDLE.
- Undefined (default):
  - Round-robin as described in Behaviour; no requester is granted twice in a row while the other is waiting.

Test Plan:
- Single request: req0 valid with op1=5, op2=3, sel=4'b0010 at cycle 0 -> req0_ready_o=1 at cycle 0; alu_op1_o=5 and alu_sel_o=2 from cycle 1; rsp0_valid_o=1, rsp0_result_o=8, rsp0_zero_o=0 at cycle 2; rsp1_valid_o stays 0.
- Tie/round-robin: both valid continuously, rsp ready always high, req0 sel=0110 (7-7), req1 sel=0001 (0x0F|0xF0).
  - Grants alternate 0,1,0,1.
  - rsp0: result 0, zero 1.
  - rsp1: result 0xFF, zero 0.
- Back-pressure: after grant, hold rsp1_ready_i=0 for 5 cycles with req0 valid -> rsp1_valid_o stays high and stable, req0_ready_o=0 throughout, busy_o=1. Release -> IDLE, then req0 accepted next cycle.
- Reset mid-op: assert rstn_i low during EXEC -> all valid/ready/busy = 0 immediately, without a clock edge. After release, a new req1 is accepted normally, with no stale rsp.
- Fixed priority (ALU_ARB_FIXED_PRIO_EN defined): both valid for 4 operations -> all four grants go to requester 0; requester 1 is granted after req0 valid drops.
